serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
//  The bit cell is the gate-level 1-bit full adder (sum = a^b^c;
//  carry = (a&b)|((a^b)&c)), with a registered carry between bits.
//  Operands and carry-in are captured on a start handshake.
//  The result is returned with a one-cycle done pulse.
//  Sits between the operand source (register file or test driver) and result consumers.
// PARAMETERS
//  WIDTH  8  operand and sum width in bits; legal values are >= 2.
// PORTS
//  clk    in   1      single clock; all state updates on the rising edge
//  reset  in   1      asynchronous, active-high; clears all state immediately
//  start  in   1      request to begin an addition; sampled only in IDLE or DONE
//  a      in   WIDTH  operand A; captured when start is accepted
//  b      in   WIDTH  operand B; captured when start is accepted
//  cin    in   1      carry-in; captured when start is accepted
//  busy   out  1      1 while state is RUN
//  done   out  1      1 for exactly one cycle when the result is loaded
//  sum    out  WIDTH  registered result; holds until the next completion
//  cout   out  1      registered carry-out; holds until the next completion
// BEHAVIOUR
//  Reset values: state=IDLE; busy=0; done=0; sum=0; cout=0.
//   Internal shift registers, carry and counter are all 0.
//  Reset mid-operation: immediate return to IDLE with all outputs 0.
//   No done pulse; the partial result is discarded.
//  States: IDLE, RUN, DONE. Encoding is free; no other reachable states.
//  IDLE:
//   - start=1 at an edge: load A_sh=a, B_sh=b, c_reg=cin, cnt=0, S_sh=0; go to RUN.
//   - start=0: stay in IDLE.
//  RUN (busy=1), each edge:
//   - s = A_sh[0]^B_sh[0]^c_reg;
//     c_reg <= (A_sh[0]&B_sh[0]) | ((A_sh[0]^B_sh[0])&c_reg).
//   - S_sh <= {s, S_sh[WIDTH-1:1]}; A_sh and B_sh shift right, zero-fill; cnt <= cnt+1.
//   - When cnt==WIDTH-1: sum <= {s, S_sh[WIDTH-1:1]}, cout <= new carry; go to DONE.
//  DONE: done=1, busy=0 for one cycle; next state IDLE.
//   - start=1 in DONE is accepted exactly as in IDLE (load, go to RUN).
//   - This allows back-to-back operations.
//  Latency: start sampled high at edge T -> done=1 from edge T+WIDTH to edge T+WIDTH+1.
//   sum and cout are valid at edge T+WIDTH.
//  Throughput: one result per WIDTH+1 cycles when start is held high.
//  start, a, b and cin are ignored during RUN.
//   Operand changes after acceptance do not affect the result.
//  sum and cout keep the previous result throughout RUN; they change only at the DONE transition.
//  Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
//  cnt width = clog2(WIDTH); it must not wrap before WIDTH-1 is reached.
// TESTING (WIDTH=8)
//  1. Assert reset with no clock -> busy=0, done=0, sum=00, cout=0 immediately.
//  2. a=3C, b=5A, cin=0, start at edge T -> done at T+8 only; sum=96, cout=0;
//     busy=1 for edges T..T+7.
//  3. a=FF, b=01, cin=0 -> sum=00, cout=1.
//     Then a=FF, b=FF, cin=1 -> sum=FF, cout=1.
//  4. Start a=10, b=20; at RUN cycle 3 drive start=1, a=FF, b=FF
//     -> single done pulse, sum=30, cout=0.
//  5. Assert reset during RUN cycle 4 -> outputs 0 at once, no done.
//     A fresh start with a=01, b=01 then gives sum=02.
//  6. Exhaustive sweep: a, b over 0..FF and cin over 0..1, start held high
//     -> each done matches a+b+cin; done spacing is 9 cycles.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Adds two WIDTH-bit operands plus a carry-in,
//            LSB first, one bit per clock, through a gate-level full-adder
//            cell with a registered carry between bit positions.
//            Operands and carry-in are captured when start is accepted
//            (state IDLE or DONE). The result is loaded into sum/cout
//            together with a one-cycle done pulse.
// Ports    : clk    - rising-edge clock
//            reset  - asynchronous active-high reset, clears all state
//            start  - begin an addition (sampled only in IDLE or DONE)
//            a, b   - WIDTH-bit operands, captured when start is accepted
//            cin    - carry-in, captured when start is accepted
//            busy   - high while the adder is stepping through the bits
//            done   - one-cycle pulse when sum/cout are loaded
//            sum    - registered result, holds until the next completion
//            cout   - registered carry-out, holds until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1, so clog2(WIDTH) bits never wrap early.
    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_s_sh;
    logic               r_carry;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    // Full-adder bit cell on the current LSBs.
    logic             w_prop;
    logic             w_gen;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_s_next;

    assign w_prop   = r_a_sh[0] ^ r_b_sh[0];
    assign w_gen    = r_a_sh[0] & r_b_sh[0];
    assign w_s      = w_prop ^ r_carry;
    assign w_c      = w_gen | (w_prop & r_carry);
    // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    assign w_s_next = {w_s, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // DONE accepts start exactly like IDLE, enabling back-to-back operation.
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_s_sh  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_s_sh  <= w_s_next;
                    r_carry <= w_c;
                    r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_c;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
